gen3_tx_block_sched: RTL and testbench
======================================

GEN3_TX_BLOCK_SCHED -- requirements
Module: gen3_tx_block_sched

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 370, meaning data/OS blocks sent between SKP Ordered Sets (range 2..1023).
REQ-002 SHALL have port clk_i  input  1  clock; the single clock for all logic.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable_i  input  1  LTSSM permits Gen3 transmission.
REQ-005 SHALL have port data_valid_i  input  1  data-stream beat offered.
REQ-006 SHALL have port data_i  input  32  data-stream beat; [7:0] is the earliest symbol.
REQ-007 SHALL have port data_ready_o  output  1  data beat accepted when high with data_valid_i.
REQ-008 SHALL have port os_valid_i  input  1  Ordered Set beat offered.
REQ-009 SHALL have port os_data_i  input  32  Ordered Set beat; [7:0] is the earliest symbol.
REQ-010 SHALL have port os_ready_o  output  1  OS beat accepted when high with os_valid_i.
REQ-011 SHALL have port sync_header_o  output  2  sync header to the scrambler, valid on beat 0 only.
REQ-012 SHALL have port data_o  output  32  beat to the scrambler.
REQ-013 SHALL have port data_valid_o  output  1  data_o/sync_header_o valid.
REQ-014 SHALL have port block_start_o  output  1  high on beat 0 of each block.
REQ-015 SHALL have port skp_sent_o  output  1  one-cycle pulse on the last beat of each SKP block.

Function
REQ-016 SHALL send a block as 4 beats of 32 bits (16 symbols), counted by a 2-bit beat counter that wraps 3->0.
REQ-017 SHALL use FSM states IDLE, DATA, OS, SKP; the state holds the type of the block in progress.
REQ-018 SHALL arbitrate only at a block boundary (IDLE, or the cycle after beat 3 completes) with priority: SKP pending > os_valid_i > data_valid_i.
REQ-019 SHALL grant only when enable_i is high at the boundary; with no grant the state SHALL be IDLE and data_valid_o low.
REQ-020 SHALL make the grant combinational, so the boundary cycle itself carries beat 0 of the granted block: no idle cycle between back-to-back blocks.
REQ-021 SHALL drive data_ready_o high only in state DATA or for a DATA grant at the boundary; os_ready_o likewise for OS; both SHALL be low in SKP.
REQ-022 SHALL register all outputs: an accepted beat appears on data_o/data_valid_o exactly 1 cycle later.
REQ-023 SHALL stall within a DATA/OS block when the owning valid is low: beat counter held, data_valid_o low that cycle, block not abandoned.
REQ-024 SHALL complete a block once started, even if enable_i drops mid-block.
REQ-025 SHALL drive sync_header_o = 2'b01 for DATA, 2'b10 for OS and SKP on beat 0, and 2'b00 on other beats.
REQ-026 SHALL generate SKP internally: beats 0-2 = 32'hAAAAAAAA, beat 3 = 32'h000000E1; SKP beats never stall.
REQ-027 SHALL count completed DATA and OS blocks in a 10-bit counter and set skp_pending when the count reaches SKP_INTERVAL; the counter SHALL saturate while pending.
REQ-028 SHALL clear skp_pending and zero the counter on the SKP grant cycle; a block completing in that same cycle SHALL not be counted.
REQ-029 SHALL raise skp_sent_o with the registered output of SKP beat 3.

Reset
REQ-030 SHALL, while rst_ni is low: state IDLE, beat counter 0, block counter 0, skp_pending 0, all outputs 0.
REQ-031 SHALL abandon any block in progress on reset assertion; after release the first block SHALL start at beat 0.

Verification
REQ-032 Continuous data_valid_i with enable_i=1 -> a sync 01 beat every 4 cycles, no gaps, 1-cycle latency, data_o equal to data_i.
REQ-033 os_valid_i and data_valid_i both high at a boundary -> OS block (sync 10) sent first, data_ready_o low during those 4 beats.
REQ-034 SKP_INTERVAL=4, continuous data -> after 4 DATA blocks, SKP sent: AAAAAAAA x3 then 000000E1, skp_sent_o pulses once, then data resumes.
REQ-035 data_valid_i dropped for 2 cycles at beat 2 -> data_valid_o low for 2 cycles, block resumes at beat 2 and the beat order is preserved.
REQ-036 enable_i dropped at beat 1 -> block finishes its 4 beats, then IDLE; rst_ni pulsed mid-block -> all outputs 0 at once, and the next block starts at beat 0 with sync header set.

Source files
------------

// File: rtl/gen3_tx_block_sched.sv
// Gen3 128b/130b transmit block scheduler: arbitrates SKP / Ordered Set / data blocks
// at block boundaries and streams each block as four registered 32-bit beats.
module gen3_tx_block_sched #(
  parameter int unsigned SKP_INTERVAL = 370
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        data_ready_o,
  input  logic        os_valid_i,
  input  logic [31:0] os_data_i,
  output logic        os_ready_o,
  output logic [1:0]  sync_header_o,
  output logic [31:0] data_o,
  output logic        data_valid_o,
  output logic        block_start_o,
  output logic        skp_sent_o
);

  typedef enum logic [1:0] {IDLE, DATA, OS, SKP} state_e;

  localparam logic [9:0] SKP_CNT = 10'(SKP_INTERVAL);

  state_e      state_q, state_d, cur_state;
  logic [1:0]  beat_q, beat_d;
  logic [9:0]  blk_cnt_q, blk_cnt_d;
  logic        skp_pend_q, skp_pend_d;
  logic [1:0]  sync_q, sync_d;
  logic [31:0] dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        bs_q, bs_d;
  logic        skp_sent_q, skp_sent_d;
  logic        fire, blk_done, skp_grant;
  logic [31:0] beat_data;
  logic [1:0]  hdr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      blk_cnt_q  <= '0;
      skp_pend_q <= 1'b0;
      sync_q     <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      bs_q       <= 1'b0;
      skp_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      blk_cnt_q  <= blk_cnt_d;
      skp_pend_q <= skp_pend_d;
      sync_q     <= sync_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      bs_q       <= bs_d;
      skp_sent_q <= skp_sent_d;
    end
  end

  // IDLE is the boundary: the grant resolves combinationally so this cycle carries beat 0.
  always_comb begin
    cur_state = state_q;
    if (state_q == IDLE) begin
      cur_state = IDLE;
      if (enable_i && rst_ni) begin
        if (skp_pend_q)        cur_state = SKP;
        else if (os_valid_i)   cur_state = OS;
        else if (data_valid_i) cur_state = DATA;
      end
    end
  end

  always_comb begin
    state_d    = cur_state;
    beat_d     = beat_q;
    blk_cnt_d  = blk_cnt_q;
    skp_pend_d = skp_pend_q;
    blk_done   = fire && (beat_q == 2'd3) && (cur_state == DATA || cur_state == OS);
    skp_grant  = (state_q == IDLE) && (cur_state == SKP);
    if (fire) begin
      beat_d = beat_q + 2'd1;
      if (beat_q == 2'd3) state_d = IDLE;
    end
    if (skp_grant) begin
      blk_cnt_d  = '0;
      skp_pend_d = 1'b0;
    end else if (blk_done && !skp_pend_q) begin
      blk_cnt_d = blk_cnt_q + 10'd1;
      if (blk_cnt_d == SKP_CNT) skp_pend_d = 1'b1;
    end
  end

  always_comb begin
    data_ready_o = (cur_state == DATA);
    os_ready_o   = (cur_state == OS);
    fire         = 1'b0;
    beat_data    = '0;
    hdr          = 2'b10;
    unique case (cur_state)
      DATA: begin
        fire      = data_valid_i;
        beat_data = data_i;
        hdr       = 2'b01;
      end
      OS: begin
        fire      = os_valid_i;
        beat_data = os_data_i;
      end
      SKP: begin
        fire      = 1'b1;
        beat_data = (beat_q == 2'd3) ? 32'h0000_00E1 : 32'hAAAA_AAAA;
      end
      default: ;
    endcase
    vld_d      = fire;
    dout_d     = fire ? beat_data : '0;
    sync_d     = (fire && beat_q == 2'd0) ? hdr : 2'b00;
    bs_d       = fire && (beat_q == 2'd0);
    skp_sent_d = fire && (cur_state == SKP) && (beat_q == 2'd3);
  end

  assign sync_header_o = sync_q;
  assign data_o        = dout_q;
  assign data_valid_o  = vld_q;
  assign block_start_o = bs_q;
  assign skp_sent_o    = skp_sent_q;

endmodule

// File: tb/tb_gen3_tx_block_sched.sv
// Scoreboard bench for gen3_tx_block_sched: accepted beats and implied SKP blocks are
// queued as expected output beats and compared as the scheduler emits them.
module tb_gen3_tx_block_sched;
  localparam int unsigned SKP_INT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        data_valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        data_ready_o;
  logic        os_valid_i = 1'b0;
  logic [31:0] os_data_i = '0;
  logic        os_ready_o;
  logic [1:0]  sync_header_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        block_start_o;
  logic        skp_sent_o;

  gen3_tx_block_sched #(.SKP_INTERVAL(SKP_INT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .os_valid_i(os_valid_i), .os_data_i(os_data_i), .os_ready_o(os_ready_o),
    .sync_header_o(sync_header_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .block_start_o(block_start_o), .skp_sent_o(skp_sent_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  sync;
    logic [31:0] data;
    logic        bs;
    logic        skp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mdl_beat = 0, mdl_blocks = 0;
  int   first_out = 0, last_out = 0, out_cnt = 0, skp_cnt = 0, first_acc = 0;
  bit   first_out_seen = 0, first_acc_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compare emitted beats, then queue what is about to be accepted.
  always @(negedge clk_i) begin
    exp_t e;
    bit   acc, is_os;
    logic [31:0] d;
    if (!rst_ni) begin
      q.delete();
      mdl_beat   = 0;
      mdl_blocks = 0;
    end else begin
      if (data_valid_o) begin
        out_cnt++;
        last_out = cyc;
        if (!first_out_seen) begin first_out = cyc; first_out_seen = 1; end
        if (skp_sent_o) skp_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got sync=%b data=%h, required no output beat", sync_header_o, data_o);
        end else begin
          e = q.pop_front();
          if ({sync_header_o, data_o, block_start_o, skp_sent_o} !== e) begin
            errors++;
            $display("FAIL sb_beat: got sync=%b data=%h bs=%b skp=%b, required sync=%b data=%h bs=%b skp=%b",
                     sync_header_o, data_o, block_start_o, skp_sent_o, e.sync, e.data, e.bs, e.skp);
          end
        end
      end else if (skp_sent_o) begin
        skp_cnt++;
      end
      acc   = 0;
      is_os = 0;
      d     = '0;
      if (os_valid_i && os_ready_o) begin acc = 1; is_os = 1; d = os_data_i; end
      else if (data_valid_i && data_ready_o) begin acc = 1; d = data_i; end
      if (acc) begin
        if (!first_acc_seen) begin first_acc = cyc; first_acc_seen = 1; end
        e.sync = (mdl_beat == 0) ? (is_os ? 2'b10 : 2'b01) : 2'b00;
        e.data = d;
        e.bs   = (mdl_beat == 0);
        e.skp  = 1'b0;
        q.push_back(e);
        if (mdl_beat == 3) begin
          mdl_beat = 0;
          mdl_blocks++;
          if (mdl_blocks == int'(SKP_INT)) begin
            mdl_blocks = 0;
            for (int i = 0; i < 4; i++) begin
              e.sync = (i == 0) ? 2'b10 : 2'b00;
              e.data = (i == 3) ? 32'h0000_00E1 : 32'hAAAA_AAAA;
              e.bs   = (i == 0);
              e.skp  = (i == 3);
              q.push_back(e);
            end
          end
        end else begin
          mdl_beat++;
        end
      end
    end
  end

  task automatic clear_stats();
    first_out_seen = 0;
    first_acc_seen = 0;
    out_cnt        = 0;
    skp_cnt        = 0;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    enable_i     = 1'b0;
    data_valid_i = 1'b0;
    os_valid_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    clear_stats();
  endtask

  task automatic send(input bit is_os, input logic [31:0] base, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      if (is_os) begin os_valid_i = 1'b1; os_data_i = base + 32'(i); end
      else begin data_valid_i = 1'b1; data_i = base + 32'(i); end
      w = 0;
      @(negedge clk_i);
      while (!(is_os ? os_ready_o : data_ready_o) && w < 50) begin
        @(negedge clk_i);
        w++;
      end
      checks++;
      if (!(is_os ? os_ready_o : data_ready_o)) begin
        errors++;
        $display("FAIL send_timeout: beat %0d not accepted after %0d cycles, required acceptance", i, w);
        data_valid_i = 1'b0;
        os_valid_i   = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    data_valid_i = 1'b0;
    os_valid_i   = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk_i);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected beats never emitted, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({data_valid_o, sync_header_o, data_o, block_start_o, skp_sent_o, data_ready_o, os_ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b sync=%b data=%h bs=%b skp=%b rdy=%b osrdy=%b, required all 0",
               data_valid_o, sync_header_o, data_o, block_start_o, skp_sent_o, data_ready_o, os_ready_o);
    end
    enable_i = 1'b0;
    rst_ni   = 1'b1;
    clear_stats();
    @(negedge clk_i);
    checks++;
    if (data_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL no_grant_ready: got data_ready_o=%b, required 0 with enable_i low", data_ready_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL no_grant_valid: got data_valid_o=%b, required 0 with enable_i low", data_valid_o);
    end
    data_valid_i = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    enable_i = 1'b1;
    send(0, 32'h1000_0000, 12);
    drain();
    checks++;
    if (first_out != first_acc + 1) begin
      errors++;
      $display("FAIL stream_latency: got first output %0d cycles after acceptance, required 1", first_out - first_acc);
    end
    checks++;
    if (last_out - first_out != 11 || out_cnt != 12) begin
      errors++;
      $display("FAIL stream_gapless: got %0d beats over span %0d, required 12 beats over span 11", out_cnt, last_out - first_out);
    end
  endtask

  task automatic test_skp();
    do_reset();
    enable_i = 1'b1;
    send(0, 32'h2000_0000, 20);
    drain();
    checks++;
    if (out_cnt != 24 || last_out - first_out != 23) begin
      errors++;
      $display("FAIL skp_stream: got %0d beats over span %0d, required 24 beats over span 23", out_cnt, last_out - first_out);
    end
    checks++;
    if (skp_cnt != 1) begin
      errors++;
      $display("FAIL skp_pulse: got %0d skp_sent pulses, required 1", skp_cnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    data_i       = 32'h3000_0000;
    os_valid_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      os_data_i = 32'h3100_0000 + 32'(i);
      @(negedge clk_i);
      checks++;
      if (os_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL priority_ready: beat %0d got os_ready=%b data_ready=%b, required 1 and 0", i, os_ready_o, data_ready_o);
      end
      @(posedge clk_i);
      #1;
    end
    os_valid_i = 1'b0;
    send(0, 32'h3000_0000, 4);
    drain();
    checks++;
    if (out_cnt != 8) begin
      errors++;
      $display("FAIL priority_count: got %0d beats, required 8", out_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    data_i       = 32'h4000_0000;
    @(posedge clk_i); #1;
    data_i = 32'h4000_0001;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (data_valid_o !== 1'b0 || data_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_gap: cycle %0d got vld=%b ready=%b, required 0 and 1", i, data_valid_o, data_ready_o);
      end
    end
    data_valid_i = 1'b1;
    data_i       = 32'h4000_0002;
    @(posedge clk_i); #1;
    checks++;
    if (data_valid_o !== 1'b1 || data_o !== 32'h4000_0002 || sync_header_o !== 2'b00) begin
      errors++;
      $display("FAIL stall_resume: got vld=%b data=%h sync=%b, required 1 40000002 00", data_valid_o, data_o, sync_header_o);
    end
    data_i = 32'h4000_0003;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    drain();
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    data_i       = 32'h6000_0000;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      data_i = 32'h6000_0000 + 32'(i);
      @(negedge clk_i);
      checks++;
      if (data_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL enable_drop_finish: beat %0d got data_ready=%b, required 1", i, data_ready_o);
      end
      @(posedge clk_i); #1;
    end
    data_i = 32'h6000_0004;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (data_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL enable_drop_idle: got data_ready=%b, required 0", data_ready_o);
      end
    end
    @(posedge clk_i); #1;
    checks++;
    if (data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop_valid: got data_valid_o=%b, required 0", data_valid_o);
    end
    data_valid_i = 1'b0;
    drain();
    checks++;
    if (out_cnt != 4) begin
      errors++;
      $display("FAIL enable_drop_count: got %0d beats, required 4", out_cnt);
    end
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    data_i       = 32'h5000_0000;
    @(posedge clk_i); #1;
    data_i = 32'h5000_0001;
    @(posedge clk_i); #1;
    rst_ni       = 1'b0;
    data_valid_i = 1'b0;
    #1;
    checks++;
    if ({data_valid_o, sync_header_o, data_o, block_start_o, skp_sent_o, data_ready_o, os_ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got vld=%b sync=%b data=%h bs=%b, required all 0",
               data_valid_o, sync_header_o, data_o, block_start_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    clear_stats();
    send(0, 32'h5100_0000, 4);
    drain();
    checks++;
    if (out_cnt != 4) begin
      errors++;
      $display("FAIL reset_mid_restart: got %0d beats after reset, required 4", out_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skp();
    test_priority();
    test_stall();
    test_enable_drop();
    test_reset_mid_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1);
  end

endmodule
